bin2bcd_seq: RTL and testbench

- Parametrised sequential binary-to-BCD converter using the double-dabble (shift/add-3) method.
- Generalises the existing fixed 5-bit combinational converter to any WIDTH/DIGITS. Adds a start/busy/done handshake and overflow detection.
- Sits between the ALU/register-file result path and the seven-segment display driver. One conversion costs WIDTH+1 cycles, trading latency for area.

---
 rtl/bin2bcd_seq.sv | 178 +++++++++++++++++
 tb/tb_bin2bcd_seq.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential binary-to-BCD converter (double dabble, shift/add-3).
// One bit of the operand is shifted into the BCD accumulator per cycle, so a
// conversion takes WIDTH shift cycles plus one DONE cycle (WIDTH+1 total).
//
// Parameters:
//   WIDTH   binary operand width (>= 2)
//   DIGITS  number of BCD output digits; too few digits sets ovf and leaves
//           the value modulo 10^DIGITS in bcd_out
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high
//   start    conversion request, sampled only in IDLE
//   bin_in   operand, captured on the accepted start edge
//   busy     high in SHIFT and DONE
//   done     single-cycle pulse, result valid from this cycle on
//   bcd_out  packed BCD result, digit 0 (ones) in bits [3:0]
//   ovf      result needed more than DIGITS digits
//   neg      sign of the result
//
// Optional build macro BIN2BCD_SIGNED_EN: bin_in is two's complement, the
// magnitude is converted and neg carries the sign. Without it bin_in is
// unsigned and neg is tied low.

module bin2bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf,
  output logic                  neg
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   op_q, op_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   load_op;
  logic [BCD_W-1:0]   acc_adj;
  // {carry-out of top digit, accumulator, operand} after the left shift
  logic [BCD_W+WIDTH:0] shifted;

`ifdef BIN2BCD_SIGNED_EN
  localparam logic [WIDTH-1:0] OP_ONE = WIDTH'(1);

  logic sign_q, sign_d;
  logic neg_q, neg_d;
  logic load_sign;

  // Negative operands are converted as their magnitude; the most negative
  // value maps onto itself, which read unsigned is the full magnitude.
  assign load_sign = bin_in[WIDTH-1];
  assign load_op   = load_sign ? (~bin_in + OP_ONE) : bin_in;
  assign neg       = neg_q;
`else
  assign load_op   = bin_in;
  assign neg       = 1'b0;
`endif

  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

  // Add-3 correction per digit, independent of neighbouring digits.
  always_comb begin
    acc_adj = acc_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    shifted = {acc_adj, op_q, 1'b0};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef BIN2BCD_SIGNED_EN
    sign_d    = sign_q;
    neg_d     = neg_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = load_op;
          acc_d     = '0;
          ovf_acc_d = 1'b0;
          cnt_d     = CNT_LOAD;
`ifdef BIN2BCD_SIGNED_EN
          sign_d    = load_sign;
`endif
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        acc_d     = shifted[BCD_W+WIDTH-1:WIDTH];
        op_d      = shifted[WIDTH-1:0];
        // Any bit pushed out of the top digit means the value needs more digits.
        ovf_acc_d = ovf_acc_q | shifted[BCD_W+WIDTH];
        cnt_d     = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          bcd_d   = shifted[BCD_W+WIDTH-1:WIDTH];
          ovf_d   = ovf_acc_q | shifted[BCD_W+WIDTH];
`ifdef BIN2BCD_SIGNED_EN
          neg_d   = sign_q;
`endif
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef BIN2BCD_SIGNED_EN
      sign_q    <= 1'b0;
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
`ifdef BIN2BCD_SIGNED_EN
      sign_q    <= sign_d;
      neg_q     <= neg_d;
`endif
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Testbench for bin2bcd_seq: one 3-digit and one 2-digit instance share the
// same stimulus; results are compared against a decimal arithmetic model.

module tb_bin2bcd_seq;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 3;
  localparam int unsigned D2 = 2;

  logic              clk;
  logic              rst;
  logic              start;
  logic [W-1:0]      bin_in;
  logic              busy, done, ovf, neg;
  logic [4*D-1:0]    bcd_out;
  logic              busy2, done2, ovf2, neg2;
  logic [4*D2-1:0]   bcd_out2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] prev_bcd  = '0;
  logic [31:0] prev_bcd2 = '0;

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf), .neg(neg)
  );

  bin2bcd_seq #(.WIDTH(W), .DIGITS(D2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy2), .done(done2), .bcd_out(bcd_out2), .ovf(ovf2), .neg(neg2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned magnitude(input logic [W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    if (v[W-1]) return (1 << W) - int'(v);
`endif
    return int'(v);
  endfunction

  function automatic logic exp_sign(input logic [W-1:0] v);
`ifdef BIN2BCD_SIGNED_EN
    return v[W-1];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] to_bcd(input int unsigned val, input int unsigned nd);
    logic [31:0] res = '0;
    int unsigned x = val;
    for (int unsigned d = 0; d < nd; d++) begin
      res = res | ((x % 10) << (4 * d));
      x = x / 10;
    end
    return res;
  endfunction

  function automatic logic too_big(input int unsigned val, input int unsigned nd);
    int unsigned lim = 1;
    for (int unsigned d = 0; d < nd; d++) lim = lim * 10;
    return val >= lim;
  endfunction

  task automatic check_result(input logic [W-1:0] v);
    int unsigned m = magnitude(v);
    check("bcd_d3",  32'(bcd_out),  to_bcd(m, D));
    check("ovf_d3",  32'(ovf),      32'(too_big(m, D)));
    check("neg_d3",  32'(neg),      32'(exp_sign(v)));
    check("bcd_d2",  32'(bcd_out2), to_bcd(m, D2));
    check("ovf_d2",  32'(ovf2),     32'(too_big(m, D2)));
    check("neg_d2",  32'(neg2),     32'(exp_sign(v)));
    prev_bcd  = to_bcd(m, D);
    prev_bcd2 = to_bcd(m, D2);
  endtask

  task automatic wait_done(output int unsigned cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_conv(input logic [W-1:0] v);
    int unsigned cyc;
    start  = 1'b1;
    bin_in = v;
    tick();
    start  = 1'b0;
    bin_in = W'($urandom);
    check("busy_after_start", 32'(busy), 32'd1);
    check("hold_bcd", 32'(bcd_out), prev_bcd);
    check("hold_bcd2", 32'(bcd_out2), prev_bcd2);
    wait_done(cyc);
    check("latency", cyc, W);
    check("done2_aligned", 32'(done2), 32'd1);
    check_result(v);
    tick();
    check("done_single", 32'(done), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_bcd"},  32'(bcd_out), 32'd0);
    check({tag, "_ovf"},  32'(ovf), 32'd0);
    check({tag, "_neg"},  32'(neg), 32'd0);
    check({tag, "_bcd2"}, 32'(bcd_out2), 32'd0);
    check({tag, "_ovf2"}, 32'(ovf2), 32'd0);
  endtask

  initial begin
    int unsigned cyc;
    int unsigned pulses;
    logic [31:0] seen_bcd;

    rst = 1'b1; start = 1'b0; bin_in = '0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // zero operand, latency and busy span
    run_conv(W'(0));

    // directed boundary values
    run_conv(W'(255));
    run_conv(W'(99));
    run_conv(W'(128));
    run_conv(W'(127));
    run_conv(W'(100));

    // back-to-back with start held high
    start = 1'b1; bin_in = W'(255);
    tick();
    bin_in = W'(99);
    wait_done(cyc);
    check("b2b_lat1", cyc, W);
    check_result(W'(255));
    tick();
    cyc = 1;
    while (!done && cyc < 40) begin
      tick();
      cyc++;
    end
    check("b2b_period", cyc, W + 2);
    check_result(W'(99));
    start = 1'b0;
    tick();

    // start pulsed during SHIFT is ignored
    start = 1'b1; bin_in = W'(137);
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; bin_in = W'(5);
    tick();
    start = 1'b0;
    pulses = 0; seen_bcd = '0;
    for (int i = 0; i < 16; i++) begin
      if (done) begin
        pulses++;
        seen_bcd = 32'(bcd_out);
      end
      tick();
    end
    check("ignore_start_pulses", pulses, 32'd1);
    check("ignore_start_bcd", seen_bcd, to_bcd(magnitude(W'(137)), D));
    prev_bcd  = to_bcd(magnitude(W'(137)), D);
    prev_bcd2 = to_bcd(magnitude(W'(137)), D2);

    // reset mid-conversion aborts
    start = 1'b1; bin_in = W'(200);
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("abort");
    prev_bcd = '0; prev_bcd2 = '0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || done2) pulses++;
      tick();
    end
    check("abort_no_done", pulses, 32'd0);
    run_conv(W'(42));

    // randomized operands
    for (int i = 0; i < 40; i++) begin
      run_conv(W'($urandom));
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
